multi_tick_generator: RTL and testbench

MULTI_TICK_GENERATOR -- requirements
Module: multi_tick_generator

---
 rtl/multi_tick_generator.sv | 128 ++++++++++++
 tb/tb_multi_tick_generator.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_tick_generator.sv
// multi_tick_generator
// NUM_CH independent programmable clock-enable dividers. Each channel emits a
// one-cycle tick every div_eff enabled cycles and a square wave that toggles
// on every tick. One shared config slot updates divisors. A new divisor is
// held as pending and loaded only at a safe point of the target channel
// (wrap, clear or pause), so a running period is never cut short.
module multi_tick_generator #(
   parameter int NUM_CH      = 4,
   parameter int CNT_W       = 16,
   parameter int DEFAULT_DIV = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NUM_CH-1:0] enable,
   input  logic [NUM_CH-1:0] clear,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [3:0]        cfg_ch,
   input  logic [CNT_W-1:0]  cfg_div,
   output logic              cfg_err,
   output logic [NUM_CH-1:0] tick,
   output logic [NUM_CH-1:0] square
);

   localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);

   // Terminal count for a divisor: div_eff-1, where a divisor of 0 acts as 1.
   function automatic logic [CNT_W-1:0] last_count(input logic [CNT_W-1:0] d);
      last_count = (d == '0) ? '0 : d - 1'b1;
   endfunction

   logic [CNT_W-1:0] cnt_q    [NUM_CH];
   logic [CNT_W-1:0] div_q    [NUM_CH];
   logic             tick_q   [NUM_CH];
   logic             square_q [NUM_CH];

   logic             pending_q;
   logic [3:0]       pend_ch_q;
   logic [CNT_W-1:0] pend_div_q;
   logic             cfg_err_q;

   logic [NUM_CH-1:0] wrap;
   logic [NUM_CH-1:0] reload_hit;
   logic              reload_any;
   logic              accept;
   logic              ch_in_range;

   assign accept      = cfg_valid & ~pending_q;
   assign ch_in_range = ({1'b0, cfg_ch} < 5'(NUM_CH));
   assign reload_any  = |reload_hit;

   assign cfg_ready = ~pending_q;
   assign cfg_err   = cfg_err_q;

   genvar i;
   generate
      for (i = 0; i < NUM_CH; i++) begin : g_ch
         // A wrap is judged against the divisor in force before this edge,
         // so a reload landing on the same edge only affects the next period.
         assign wrap[i] = ~clear[i] & enable[i] &
                          (cnt_q[i] == last_count(div_q[i]));

         // Pending divisor is safe to apply when its channel wraps, is
         // cleared, or is paused.
         assign reload_hit[i] = pending_q & (pend_ch_q == 4'(i)) &
                                (wrap[i] | clear[i] | ~enable[i]);

         assign tick[i]   = tick_q[i];
         assign square[i] = square_q[i];

         // Per-channel counter, divisor, tick pulse and square level.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               cnt_q[i]    <= '0;
               div_q[i]    <= DEF_DIV;
               tick_q[i]   <= 1'b0;
               square_q[i] <= 1'b0;
            end else begin
               if (reload_hit[i]) begin
                  div_q[i] <= pend_div_q;
               end
               if (clear[i]) begin
                  cnt_q[i]    <= '0;
                  tick_q[i]   <= 1'b0;
                  square_q[i] <= 1'b0;
               end else if (enable[i]) begin
                  if (wrap[i]) begin
                     cnt_q[i]    <= '0;
                     tick_q[i]   <= 1'b1;
                     square_q[i] <= ~square_q[i];
                  end else begin
                     // Free-running add: a counter left above a shrunken
                     // divisor rolls over rather than wrapping early.
                     cnt_q[i]  <= cnt_q[i] + 1'b1;
                     tick_q[i] <= 1'b0;
                  end
               end else begin
                  tick_q[i] <= 1'b0;
               end
            end
         end
      end
   endgenerate

   // Config slot control: pending flag and out-of-range error pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending_q <= 1'b0;
         cfg_err_q <= 1'b0;
      end else begin
         cfg_err_q <= accept & ~ch_in_range;
         if (reload_any) begin
            pending_q <= 1'b0;
         end else if (accept & ch_in_range) begin
            pending_q <= 1'b1;
         end
      end
   end

   // Config slot payload; only meaningful while pending is set.
   always_ff @(posedge clk) begin
      if (accept & ch_in_range) begin
         pend_ch_q  <= cfg_ch;
         pend_div_q <= cfg_div;
      end
   end

endmodule

// File: tb/tb_multi_tick_generator.sv
// Bench for multi_tick_generator: directed table, hand-written corner
// sequences and randomized traffic against a behavioural model.
module tb_multi_tick_generator;

   localparam int NUM_CH = 4;
   localparam int CNT_W  = 16;
   localparam int DEF    = 10;
   localparam int CMASK  = (1 << CNT_W) - 1;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [NUM_CH-1:0] enable = '0;
   logic [NUM_CH-1:0] clear = '0;
   logic              cfg_valid = 1'b0;
   logic              cfg_ready;
   logic [3:0]        cfg_ch = '0;
   logic [CNT_W-1:0]  cfg_div = '0;
   logic              cfg_err;
   logic [NUM_CH-1:0] tick;
   logic [NUM_CH-1:0] square;

   int total = 0;
   int bad   = 0;

   multi_tick_generator #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEFAULT_DIV(DEF)) dut (
      .clk(clk), .rst(rst), .enable(enable), .clear(clear),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
      .cfg_div(cfg_div), .cfg_err(cfg_err), .tick(tick), .square(square)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural reference model ----------------
   int unsigned m_cnt [NUM_CH];
   int unsigned m_div [NUM_CH];
   bit          m_tick[NUM_CH];
   bit          m_sq  [NUM_CH];
   bit          m_pend;
   int          m_pch;
   int unsigned m_pdiv;
   bit          m_err;

   function automatic void m_reset();
      for (int c = 0; c < NUM_CH; c++) begin
         m_cnt[c] = 0; m_div[c] = DEF; m_tick[c] = 0; m_sq[c] = 0;
      end
      m_pend = 0; m_pch = 0; m_pdiv = 0; m_err = 0;
   endfunction

   function automatic void m_step(input logic [NUM_CH-1:0] en, input logic [NUM_CH-1:0] clr,
                                  input logic v, input logic [3:0] ch, input logic [CNT_W-1:0] d);
      bit w[NUM_CH];
      bit reload, acc;
      int unsigned period;
      for (int c = 0; c < NUM_CH; c++) begin
         period = (m_div[c] == 0) ? 1 : m_div[c];
         w[c] = !clr[c] && en[c] && (m_cnt[c] == period - 1);
      end
      reload = m_pend && (w[m_pch] || clr[m_pch] || !en[m_pch]);
      acc    = v && !m_pend;
      for (int c = 0; c < NUM_CH; c++) begin
         if (clr[c]) begin
            m_cnt[c] = 0; m_tick[c] = 0; m_sq[c] = 0;
         end else if (en[c] && w[c]) begin
            m_cnt[c] = 0; m_tick[c] = 1; m_sq[c] = !m_sq[c];
         end else if (en[c]) begin
            m_cnt[c] = (m_cnt[c] + 1) & CMASK; m_tick[c] = 0;
         end else begin
            m_tick[c] = 0;
         end
      end
      if (reload) begin
         m_div[m_pch] = m_pdiv;
         m_pend = 0;
      end
      m_err = acc && (int'(ch) >= NUM_CH);
      if (acc && int'(ch) < NUM_CH) begin
         m_pend = 1; m_pch = int'(ch); m_pdiv = d;
      end
   endfunction

   function automatic logic [31:0] m_outs();
      logic [NUM_CH-1:0] t, s;
      for (int c = 0; c < NUM_CH; c++) begin
         t[c] = m_tick[c]; s[c] = m_sq[c];
      end
      return 32'({t, s, !m_pend, m_err});
   endfunction

   initial m_reset();
   always @(posedge rst) m_reset();

   // Model advances on every edge and is compared just after it.
   always @(posedge clk) begin
      if (rst) m_reset();
      else m_step(enable, clear, cfg_valid, cfg_ch, cfg_div);
      #1;
      chk("model", 32'({tick, square, cfg_ready, cfg_err}), m_outs());
   end

   // ---------------- stimulus helpers ----------------
   task automatic edge1();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      enable = '0; clear = '0; cfg_valid = 0; cfg_ch = '0; cfg_div = '0;
      rst = 1;
      edge1();
      rst = 0;
   endtask

   typedef struct {
      logic [NUM_CH-1:0] en;
      logic [NUM_CH-1:0] clr;
      logic              v;
      logic [3:0]        ch;
      logic [CNT_W-1:0]  div;
      logic [NUM_CH-1:0] e_tick;
      logic [NUM_CH-1:0] e_sq;
      logic              e_rdy;
      logic              e_err;
   } vec_t;

   vec_t vecs[9];
   int   n_edges;
   bit   got;

   initial begin
      // en, clr, v, ch, div -> tick, square, ready, err (after the edge)
      vecs[0] = '{4'b0000, 4'b0000, 1, 4'd7, 16'd5, 4'b0000, 4'b0000, 1, 1};
      vecs[1] = '{4'b0000, 4'b0000, 1, 4'd0, 16'd3, 4'b0000, 4'b0000, 0, 0};
      vecs[2] = '{4'b0000, 4'b0000, 0, 4'd0, 16'd0, 4'b0000, 4'b0000, 1, 0};
      vecs[3] = '{4'b0001, 4'b0000, 0, 4'd0, 16'd0, 4'b0000, 4'b0000, 1, 0};
      vecs[4] = '{4'b0001, 4'b0000, 0, 4'd0, 16'd0, 4'b0000, 4'b0000, 1, 0};
      vecs[5] = '{4'b0001, 4'b0000, 0, 4'd0, 16'd0, 4'b0001, 4'b0001, 1, 0};
      vecs[6] = '{4'b0001, 4'b0000, 0, 4'd0, 16'd0, 4'b0000, 4'b0001, 1, 0};
      vecs[7] = '{4'b0001, 4'b0001, 0, 4'd0, 16'd0, 4'b0000, 4'b0000, 1, 0};
      vecs[8] = '{4'b0000, 4'b0000, 1, 4'd8, 16'd2, 4'b0000, 4'b0000, 1, 1};

      #2;
      chk("reset_outs", 32'({tick, square, cfg_ready, cfg_err}), 32'({4'b0, 4'b0, 1'b1, 1'b0}));
      edge1();
      rst = 0;

      // Directed table
      for (int k = 0; k < 9; k++) begin
         enable = vecs[k].en; clear = vecs[k].clr; cfg_valid = vecs[k].v;
         cfg_ch = vecs[k].ch; cfg_div = vecs[k].div;
         edge1();
         chk($sformatf("vec%0d", k), 32'({tick, square, cfg_ready, cfg_err}),
             32'({vecs[k].e_tick, vecs[k].e_sq, vecs[k].e_rdy, vecs[k].e_err}));
      end

      // Default divisor: ticks at enabled edges 10, 20, 30
      do_reset();
      enable = 4'b0001;
      for (int k = 1; k <= 30; k++) begin
         edge1();
         chk($sformatf("def_tick_e%0d", k), 32'(tick[0]), 32'(k % 10 == 0));
         if (k % 10 == 0) chk($sformatf("def_sq_e%0d", k), 32'(square[0]), 32'((k / 10) % 2));
      end

      // Pause keeps phase: ten enabled edges in total regardless of the gap
      do_reset();
      enable = 4'b0001;
      for (int k = 0; k < 4; k++) edge1();
      enable = 4'b0000;
      for (int k = 0; k < 5; k++) begin
         edge1();
         chk("pause_no_tick", 32'(tick[0]), 32'd0);
      end
      enable = 4'b0001;
      n_edges = 0; got = 0;
      while (!got && n_edges < 20) begin
         edge1();
         n_edges++;
         got = tick[0];
      end
      chk("pause_resume_edges", 32'(n_edges), 32'd6);

      // Reload waits for the wrap at the old divisor
      do_reset();
      enable = 4'b0010;
      edge1(); edge1();
      cfg_valid = 1; cfg_ch = 4'd1; cfg_div = 16'd4;
      edge1();
      cfg_valid = 0;
      chk("reload_rdy_e3", 32'(cfg_ready), 32'd0);
      for (int k = 4; k <= 9; k++) begin
         edge1();
         chk($sformatf("reload_rdy_e%0d", k), 32'(cfg_ready), 32'd0);
         chk($sformatf("reload_tick_e%0d", k), 32'(tick[1]), 32'd0);
      end
      edge1();
      chk("reload_tick_e10", 32'(tick[1]), 32'd1);
      chk("reload_rdy_e10", 32'(cfg_ready), 32'd1);
      for (int k = 11; k <= 18; k++) begin
         edge1();
         chk($sformatf("newdiv_tick_e%0d", k), 32'(tick[1]), 32'(k == 14 || k == 18));
      end

      // Divisor 0 behaves as 1; clear beats enable
      do_reset();
      cfg_valid = 1; cfg_ch = 4'd2; cfg_div = 16'd0;
      edge1();
      cfg_valid = 0;
      edge1();
      chk("div0_loaded_rdy", 32'(cfg_ready), 32'd1);
      enable = 4'b0100;
      for (int k = 1; k <= 6; k++) begin
         edge1();
         chk($sformatf("div0_tick_%0d", k), 32'(tick[2]), 32'd1);
         chk($sformatf("div0_sq_%0d", k), 32'(square[2]), 32'(k % 2));
      end
      clear = 4'b0100;
      edge1();
      chk("clr_en_tick", 32'(tick[2]), 32'd0);
      chk("clr_en_sq", 32'(square[2]), 32'd0);
      clear = 4'b0000;

      // Async reset with an update pending and squares high
      do_reset();
      enable = 4'b1111;
      for (int k = 0; k < 12; k++) edge1();
      cfg_valid = 1; cfg_ch = 4'd3; cfg_div = 16'd2;
      edge1();
      cfg_valid = 0;
      chk("pre_rst_pending", 32'(cfg_ready), 32'd0);
      chk("pre_rst_sq", 32'(square), 32'hF);
      #2;
      rst = 1;
      #1;
      chk("async_rst_outs", 32'({tick, square, cfg_ready, cfg_err}), 32'({4'b0, 4'b0, 1'b1, 1'b0}));
      edge1();
      rst = 0;
      for (int k = 1; k <= 12; k++) begin
         edge1();
         chk($sformatf("post_rst_tick3_e%0d", k), 32'(tick[3]), 32'(k == 10));
      end

      // Randomized traffic, checked by the model
      do_reset();
      for (int k = 0; k < 3000; k++) begin
         enable = NUM_CH'($urandom);
         for (int c = 0; c < NUM_CH; c++) clear[c] = ($urandom_range(15) == 0);
         cfg_valid = ($urandom_range(3) == 0);
         cfg_ch = 4'($urandom_range(7));
         cfg_div = CNT_W'($urandom_range(6));
         edge1();
      end
      enable = '0; clear = '0; cfg_valid = 0;
      edge1();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
